// File: rtl/player_entry_checker.sv
// -----------------------------------------------------------------------------
// player_entry_checker
//
// Reads back the player's switch entries for one round and checks them, step
// by step, against the stored colour sequence. It is the input-side
// counterpart of the colour flasher. The switches are synchronised and
// debounced. Each debounced press is checked against segment[seq_idx]. Every
// step has a timeout counted in tick pulses. Each round ends in exactly one
// done_ok or done_fail pulse.
//
// Handshake: start is a single-cycle request, taken only in IDLE. While busy
// is high, start is ignored. round_len is sampled in the cycle in which start
// is taken. There is no back-pressure, and every result is a 1-cycle pulse.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   start         1-cycle pulse that begins checking a round
//   round_len     number of colours in the round (1..32)
//   player_input  raw switches; colour code c corresponds to bit c
//   tick          1-cycle timer pulse used for the per-step timeout
//   seq_idx       index of the sequence entry currently expected (read port)
//   seq_colour    segment[seq_idx], combinational from the sequence store
//   busy          high in WAIT_PRESS and WAIT_RELEASE
//   step_done     1-cycle pulse per correct press, issued on release
//   done_ok       1-cycle pulse: whole round entered correctly
//   done_fail     1-cycle pulse: wrong colour, several switches, or timeout
//   state_dbg     current FSM state, for observation only
// -----------------------------------------------------------------------------
module player_entry_checker #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int TIMEOUT_PULSES  = 8,
    parameter int IDX_W           = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] round_len,
    input  logic [3:0]       player_input,
    input  logic             tick,
    output logic [IDX_W-1:0] seq_idx,
    input  logic [1:0]       seq_colour,
    output logic             busy,
    output logic             step_done,
    output logic             done_ok,
    output logic             done_fail,
    output logic [2:0]       state_dbg
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_PULSES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_PULSES - 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WAIT_PRESS   = 3'd1,
        S_WAIT_RELEASE = 3'd2,
        S_PASS         = 3'd3,
        S_FAIL         = 3'd4
    } state_t;

    state_t           state;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       cand;
    logic [3:0]       stable;
    logic [CNT_W-1:0] db_cnt;
    logic             press_evt;
    logic             release_evt;
    logic [IDX_W-1:0] len;
    logic [TO_W-1:0]  timeout;

    assign state_dbg = state;

    // Input conditioning. cand holds the last synchronised sample. db_cnt
    // counts how many consecutive samples have equalled cand. The sample
    // that exposes a change is the first equal sample, so the count
    // restarts at 1. stable takes the new value on the DEBOUNCE_CYCLES-th
    // equal sample. The press and release strobes are registered alongside
    // stable, so the FSM sees each strobe together with the new stable value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= 4'b0;
            sync2       <= 4'b0;
            cand        <= 4'b0;
            stable      <= 4'b0;
            db_cnt      <= '0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            sync1       <= player_input;
            sync2       <= sync1;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            if (sync2 != cand) begin
                cand   <= sync2;
                db_cnt <= CNT_W'(1);
            end else begin
                if (db_cnt < CNT_MAX) begin
                    db_cnt <= db_cnt + 1'b1;
                end
                if (db_cnt >= CNT_FIRE && cand != stable) begin
                    stable      <= cand;
                    // A change from one nonzero value to another is neither
                    // a press nor a release.
                    press_evt   <= (stable == 4'b0);
                    release_evt <= (cand == 4'b0);
                end
            end
        end
    end

    // Round FSM. All status outputs are registered. PASS and FAIL each last
    // one cycle, and they emit their result pulse on the way back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            seq_idx   <= '0;
            len       <= '0;
            timeout   <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            done_ok   <= 1'b0;
            done_fail <= 1'b0;
        end else begin
            step_done <= 1'b0;
            done_ok   <= 1'b0;
            done_fail <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (round_len != '0) begin
                            len     <= round_len;
                            seq_idx <= '0;
                            timeout <= '0;
                            busy    <= 1'b1;
                            state   <= S_WAIT_PRESS;
                        end else begin
                            state <= S_FAIL;
                        end
                    end
                end
                S_WAIT_PRESS: begin
                    // If a press and a tick arrive in the same cycle, the
                    // press is decided and the tick is dropped.
                    if (press_evt) begin
                        if (stable == (4'b0001 << seq_colour)) begin
                            state <= S_WAIT_RELEASE;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_FAIL;
                        end
                    end else if (tick) begin
                        if (timeout == TO_LAST) begin
                            busy  <= 1'b0;
                            state <= S_FAIL;
                        end else begin
                            timeout <= timeout + 1'b1;
                        end
                    end
                end
                S_WAIT_RELEASE: begin
                    if (release_evt) begin
                        step_done <= 1'b1;
                        if (seq_idx == len - IDX_W'(1)) begin
                            busy  <= 1'b0;
                            state <= S_PASS;
                        end else begin
                            seq_idx <= seq_idx + IDX_W'(1);
                            timeout <= '0;
                            state   <= S_WAIT_PRESS;
                        end
                    end
                end
                S_PASS: begin
                    done_ok <= 1'b1;
                    state   <= S_IDLE;
                end
                S_FAIL: begin
                    done_fail <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_entry_checker.sv
// -----------------------------------------------------------------------------
// tb_player_entry_checker
//
// Directed bench for player_entry_checker with DEBOUNCE_CYCLES=4 and
// TIMEOUT_PULSES=3. The expected pulses (step_done, done_ok, done_fail) are
// queued before the stimulus that should cause them. A monitor pops one
// entry for each cycle in which any pulse is high. Status outputs are
// checked directly at fixed points. Inputs change on the falling edge, and
// outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_player_entry_checker;

    localparam int IDX_W = 6;
    localparam logic [2:0] EV_STEP = 3'b100;
    localparam logic [2:0] EV_OK   = 3'b010;
    localparam logic [2:0] EV_FAIL = 3'b001;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [IDX_W-1:0] round_len;
    logic [3:0]       player_input;
    logic             tick;
    logic [IDX_W-1:0] seq_idx;
    logic [1:0]       seq_colour;
    logic             busy;
    logic             step_done;
    logic             done_ok;
    logic             done_fail;
    logic [2:0]       state_dbg;

    logic [1:0] seq_mem [0:31];
    logic [2:0] exp_q[$];
    logic [2:0] mon_ev;
    logic [2:0] mon_exp;
    int checks = 0;
    int errors = 0;

    player_entry_checker #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_PULSES (3),
        .IDX_W          (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .round_len   (round_len),
        .player_input(player_input),
        .tick        (tick),
        .seq_idx     (seq_idx),
        .seq_colour  (seq_colour),
        .busy        (busy),
        .step_done   (step_done),
        .done_ok     (done_ok),
        .done_fail   (done_fail),
        .state_dbg   (state_dbg)
    );

    // Clock and the combinational read port of the sequence store.
    always #5 clk = ~clk;
    assign seq_colour = seq_mem[seq_idx[4:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every cycle with a pulse must match the queue head.
    always @(negedge clk) begin
        mon_ev = {step_done, done_ok, done_fail};
        if (mon_ev !== 3'b000) begin
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else                  mon_exp = 3'b000;
            chk("event", 32'(mon_ev), 32'(mon_exp));
        end
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_round(input int len);
        @(negedge clk);
        start     = 1'b1;
        round_len = IDX_W'(len);
        @(negedge clk);
        start     = 1'b0;
        round_len = '0;
    endtask

    task automatic drive_sw(input logic [3:0] v);
        @(negedge clk);
        player_input = v;
    endtask

    task automatic press_release(input logic [3:0] v);
        drive_sw(v);
        cyc(10);
        drive_sw(4'b0000);
        cyc(10);
    endtask

    task automatic tick_pulse();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc(2);
    endtask

    task automatic q_empty(input string tag);
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        round_len    = '0;
        player_input = 4'b0;
        tick         = 1'b0;
        for (int i = 0; i < 32; i++) seq_mem[i] = 2'd0;

        // Reset state
        cyc(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_seq_idx", 32'(seq_idx), 0);
        chk("rst_pulses", 32'({step_done, done_ok, done_fail}), 0);
        chk("rst_state", 32'(state_dbg), 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(2);

        // 1: len=3, sequence 2,0,3 entered correctly
        seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd3;
        exp_q.push_back(EV_STEP); exp_q.push_back(EV_STEP);
        exp_q.push_back(EV_STEP); exp_q.push_back(EV_OK);
        start_round(3);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_idx0", 32'(seq_idx), 0);
        press_release(4'b0100);
        chk("t1_idx1", 32'(seq_idx), 1);
        press_release(4'b0001);
        press_release(4'b1000);
        chk("t1_idx_end", 32'(seq_idx), 2);
        chk("t1_idle", 32'(busy), 0);
        q_empty("t1_queue");

        // 2: len=2, sequence 1,1; second press is the wrong colour
        seq_mem[0] = 2'd1; seq_mem[1] = 2'd1;
        exp_q.push_back(EV_STEP); exp_q.push_back(EV_FAIL);
        start_round(2);
        press_release(4'b0010);
        drive_sw(4'b0100);
        cyc(6);
        chk("t2_busy_before", 32'(busy), 1);
        cyc(1);
        chk("t2_busy_after", 32'(busy), 0);
        cyc(2);
        q_empty("t2_queue");
        drive_sw(4'b0000);
        cyc(10);

        // 3: two switches at once fails; bouncing input yields one press
        seq_mem[0] = 2'd0;
        exp_q.push_back(EV_FAIL);
        start_round(1);
        drive_sw(4'b0101);
        cyc(10);
        drive_sw(4'b0000);
        cyc(10);
        q_empty("t3_multi_queue");
        exp_q.push_back(EV_STEP); exp_q.push_back(EV_OK);
        start_round(1);
        for (int i = 0; i < 5; i++) begin
            drive_sw(4'b0001);
            cyc(1);
            drive_sw(4'b0000);
            cyc(1);
        end
        cyc(4);
        chk("t3_bounce_filtered", 32'(exp_q.size()), 2);
        chk("t3_bounce_busy", 32'(busy), 1);
        press_release(4'b0001);
        q_empty("t3_queue");

        // 4: timeout on the third tick, then a press coinciding with a tick
        exp_q.push_back(EV_FAIL);
        start_round(1);
        tick_pulse();
        tick_pulse();
        chk("t4_busy_2ticks", 32'(busy), 1);
        tick_pulse();
        chk("t4_busy_timeout", 32'(busy), 0);
        q_empty("t4_timeout_queue");
        exp_q.push_back(EV_STEP); exp_q.push_back(EV_OK);
        start_round(1);
        tick_pulse();
        tick_pulse();
        drive_sw(4'b0001);
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("t4_press_wins", 32'(busy), 1);
        drive_sw(4'b0000);
        cyc(10);
        q_empty("t4_queue");

        // 5: zero-length round fails; start while busy is ignored
        exp_q.push_back(EV_FAIL);
        start_round(0);
        chk("t5_fail_not_yet", 32'(done_fail), 0);
        cyc(1);
        chk("t5_fail_pulse", 32'(done_fail), 1);
        cyc(2);
        q_empty("t5_len0_queue");
        seq_mem[0] = 2'd0; seq_mem[1] = 2'd1; seq_mem[2] = 2'd2;
        exp_q.push_back(EV_STEP); exp_q.push_back(EV_FAIL);
        start_round(3);
        press_release(4'b0001);
        chk("t5_idx_step", 32'(seq_idx), 1);
        start_round(1);
        chk("t5_busy_kept", 32'(busy), 1);
        chk("t5_idx_kept", 32'(seq_idx), 1);
        tick_pulse();
        tick_pulse();
        tick_pulse();
        chk("t5_timeout_idle", 32'(busy), 0);
        chk("t5_idx_hold", 32'(seq_idx), 1);
        q_empty("t5_queue");

        // 6: reset asserted in WAIT_RELEASE, then a normal round
        seq_mem[0] = 2'd3; seq_mem[1] = 2'd0;
        start_round(2);
        drive_sw(4'b1000);
        cyc(10);
        chk("t6_held", 32'(busy), 1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_idx", 32'(seq_idx), 0);
        chk("t6_async_pulses", 32'({step_done, done_ok, done_fail}), 0);
        drive_sw(4'b0000);
        cyc(5);
        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        q_empty("t6_no_pulse");
        exp_q.push_back(EV_STEP); exp_q.push_back(EV_OK);
        start_round(1);
        chk("t6_restart_busy", 32'(busy), 1);
        press_release(4'b1000);
        chk("t6_end_idx", 32'(seq_idx), 0);
        q_empty("t6_queue");

        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
